mem_arbiter: RTL and testbench

Sequencing arbiter sharing a single-port synchronous RAM between the instruction-fetch stage (read-only) and the MEM stage (load/store). It sits between the pipeline stages and the RAM. It owns the RAM's `ram_ce` and `ram_we` controls, counts the RAM's fixed read latency, and returns data with a one-cycle ack. It also generates per-stage stall signals so the pipeline freezes while an access is outstanding.

---
 rtl/mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port synchronous RAM between the instruction
//            fetch stage (read-only) and the MEM stage (load/store). Requests
//            are sequenced one at a time through IDLE -> ISSUE -> (WAIT) ->
//            RESP. Data accesses win over fetch, except that a fetch is forced
//            after STARVE_MAX consecutive data grants made while a fetch was
//            pending.
// Ports    :
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   d_req/d_we/d_addr/d_wdata  MEM-stage request (held until d_ack)
//   d_rdata/d_ack            load data (valid with d_ack) and completion pulse
//   i_req/i_addr             fetch request (held until i_ack)
//   i_rdata/i_ack            instruction word (valid with i_ack) and pulse
//   ram_ce/ram_we/ram_addr/ram_wdata  registered RAM controls (issue cycle)
//   ram_rdata                RAM read data, valid RAM_LAT cycles after issue
//   stall_mem/stall_if       combinational per-stage stalls
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RAM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  // MEM stage
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  // Fetch stage
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  // RAM
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  // Pipeline stalls
  output logic              stall_mem,
  output logic              stall_if
);

  localparam int CNT_W = (RAM_LAT < 2) ? 1 : $clog2(RAM_LAT + 1);
  localparam int STV_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] LAT_INIT   = CNT_W'(RAM_LAT);
  localparam logic [STV_W-1:0] STARVE_LIM = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t              state_q,     state_d;
  logic                owner_q,     owner_d;     // 1 = fetch owns the transfer
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [STV_W-1:0]    starve_q,    starve_d;
  logic                ram_ce_q,    ram_ce_d;
  logic                ram_we_q,    ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q,  ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;
  logic [DATA_W-1:0]   i_rdata_q,   i_rdata_d;
  logic                d_ack_q,     d_ack_d;
  logic                i_ack_q,     i_ack_d;

  logic fetch_forced;
  logic data_win;
  logic fetch_win;

  // Data normally wins; a starved fetch overrides it.
  assign fetch_forced = i_req && (starve_q == STARVE_LIM);
  assign data_win     = d_req && !fetch_forced;
  assign fetch_win    = i_req && !data_win;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    ram_ce_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    d_rdata_d   = d_rdata_q;
    i_rdata_d   = i_rdata_q;
    d_ack_d     = 1'b0;
    i_ack_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Starvation bookkeeping happens on every IDLE cycle, granted or not.
        if (!i_req || fetch_win) begin
          starve_d = '0;
        end else if (data_win && (starve_q != STARVE_LIM)) begin
          starve_d = starve_q + STV_W'(1);
        end

        if (d_req || i_req) begin
          state_d    = ST_ISSUE;
          owner_d    = fetch_win;
          ram_ce_d   = 1'b1;
          ram_we_d   = data_win && d_we;
          ram_addr_d = data_win ? d_addr : i_addr;
          if (data_win) begin
            ram_wdata_d = d_wdata;
          end
        end
      end

      ST_ISSUE: begin
        cnt_d = LAT_INIT;
        // ram_we_q still holds the latched direction during ISSUE.
        if (ram_we_q) begin
          state_d = ST_RESP;
          d_ack_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
          if (owner_q) begin
            i_rdata_d = ram_rdata;
            i_ack_d   = 1'b1;
          end else begin
            d_rdata_d = ram_rdata;
            d_ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      starve_q    <= '0;
      ram_ce_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      d_rdata_q   <= '0;
      i_rdata_q   <= '0;
      d_ack_q     <= 1'b0;
      i_ack_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      ram_ce_q    <= ram_ce_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      d_rdata_q   <= d_rdata_d;
      i_rdata_q   <= i_rdata_d;
      d_ack_q     <= d_ack_d;
      i_ack_q     <= i_ack_d;
    end
  end

  assign ram_ce    = ram_ce_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign i_ack     = i_ack_q;

  // Stalls drop in the ack cycle so the stage advances on that edge.
  assign stall_mem = d_req && !d_ack_q;
  assign stall_if  = i_req && !i_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Scoreboard bench for mem_arbiter. Instance 0 (RAM_LAT=2) covers
//            reset, load, store, contention and reset mid-read; instances 1
//            and 2 (RAM_LAT=1 and 5) cover single fetches. Expected RAM issues
//            and acks are queued when stimulus is driven and popped when the
//            DUT produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic          d_req_a   [NI];
  logic          d_we_a    [NI];
  logic [AW-1:0] d_addr_a  [NI];
  logic [DW-1:0] d_wdata_a [NI];
  logic [DW-1:0] d_rdata_a [NI];
  logic          d_ack_a   [NI];
  logic          i_req_a   [NI];
  logic [AW-1:0] i_addr_a  [NI];
  logic [DW-1:0] i_rdata_a [NI];
  logic          i_ack_a   [NI];
  logic          ram_ce_a  [NI];
  logic          ram_we_a  [NI];
  logic [AW-1:0] ram_addr_a[NI];
  logic [DW-1:0] ram_wdata_a[NI];
  logic [DW-1:0] ram_rdata_a[NI];
  logic          stall_mem_a[NI];
  logic          stall_if_a [NI];

  function automatic int lat_of(int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 5);
  endfunction

  // Contents of the modelled RAM, a pure function of the address.
  function automatic logic [DW-1:0] ram_word(logic [AW-1:0] a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  generate
    for (genvar k = 0; k < NI; k++) begin : g_inst
      localparam int LAT = (k == 0) ? 2 : ((k == 1) ? 1 : 5);
      logic [DW-1:0] pipe [LAT];
      logic          vld  [LAT];

      mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LAT), .STARVE_MAX(4)
      ) u_dut (
        .clk(clk), .rst(rst),
        .d_req(d_req_a[k]), .d_we(d_we_a[k]), .d_addr(d_addr_a[k]),
        .d_wdata(d_wdata_a[k]), .d_rdata(d_rdata_a[k]), .d_ack(d_ack_a[k]),
        .i_req(i_req_a[k]), .i_addr(i_addr_a[k]), .i_rdata(i_rdata_a[k]),
        .i_ack(i_ack_a[k]),
        .ram_ce(ram_ce_a[k]), .ram_we(ram_we_a[k]), .ram_addr(ram_addr_a[k]),
        .ram_wdata(ram_wdata_a[k]), .ram_rdata(ram_rdata_a[k]),
        .stall_mem(stall_mem_a[k]), .stall_if(stall_if_a[k])
      );

      // Synchronous RAM: data for a read issued in cycle n is on ram_rdata
      // only in cycle n+LAT; other cycles show a junk pattern.
      always @(posedge clk) begin
        pipe[0] <= ram_word(ram_addr_a[k]);
        vld[0]  <= (ram_ce_a[k] === 1'b1) && (ram_we_a[k] === 1'b0);
        for (int s = 1; s < LAT; s++) begin
          pipe[s] <= pipe[s-1];
          vld[s]  <= vld[s-1];
        end
      end
      assign ram_rdata_a[k] = (vld[LAT-1] === 1'b1) ? pipe[LAT-1] : 32'hBAD0_BAD0;
    end
  endgenerate

  // ------------------------------------------------------------------ checks
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // -------------------------------------------------------------- scoreboard
  typedef struct {
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } ram_exp_t;

  typedef struct {
    int            k;
    int            cyc;
    bit            fetch;
    bit            store;
    logic [DW-1:0] data;
  } ack_exp_t;

  ram_exp_t      ram_q[$];
  ack_exp_t      ack_q[$];
  ram_exp_t      mon_r;
  logic [DW-1:0] last_d [NI];
  logic [DW-1:0] last_i [NI];

  function automatic int ack_cycle(int k, bit fetch, bit we, int g);
    return (we && !fetch) ? g + 2 : g + 2 + lat_of(k);
  endfunction

  // Queue the RAM issue and ack expected from a grant in cycle g.
  task automatic expect_xfer(int k, bit fetch, bit we, logic [AW-1:0] addr,
                             logic [DW-1:0] wdata, int g);
    ram_exp_t r;
    ack_exp_t a;
    if (k == 0) begin
      r.cyc = g + 1; r.we = we && !fetch; r.addr = addr; r.wdata = wdata;
      ram_q.push_back(r);
    end
    a.k = k; a.cyc = ack_cycle(k, fetch, we, g); a.fetch = fetch;
    a.store = we && !fetch; a.data = ram_word(addr);
    ack_q.push_back(a);
  endtask

  task automatic handle_ack(int k, bit fetch);
    int idx = -1;
    ack_exp_t e;
    for (int i = 0; i < ack_q.size(); i++) begin
      if (ack_q[i].k == k) begin
        idx = i;
        break;
      end
    end
    if (idx < 0) begin
      check_eq($sformatf("unexpected_ack[%0d]", k), fetch ? i_ack_a[k] : d_ack_a[k], 0);
      return;
    end
    e = ack_q[idx];
    ack_q.delete(idx);
    check_eq($sformatf("ack_cycle[%0d]", k), cyc, e.cyc);
    check_eq($sformatf("ack_owner_fetch[%0d]", k), fetch, e.fetch);
    if (fetch) begin
      check_eq($sformatf("i_rdata[%0d]", k), i_rdata_a[k], e.data);
      last_i[k] = e.data;
      check_eq($sformatf("d_rdata_hold[%0d]", k), d_rdata_a[k], last_d[k]);
    end else begin
      if (!e.store) begin
        check_eq($sformatf("d_rdata[%0d]", k), d_rdata_a[k], e.data);
        last_d[k] = e.data;
      end else begin
        check_eq($sformatf("d_rdata_store_hold[%0d]", k), d_rdata_a[k], last_d[k]);
      end
      check_eq($sformatf("i_rdata_hold[%0d]", k), i_rdata_a[k], last_i[k]);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < NI; k++) begin
        last_d[k] = '0;
        last_i[k] = '0;
      end
    end
    if (ram_ce_a[0] !== 1'b1 && ram_we_a[0] === 1'b1)
      check_eq("ram_we_without_ce", ram_we_a[0], 0);
    if (ram_ce_a[0] === 1'b1) begin
      if (ram_q.size() == 0) begin
        check_eq("unexpected_ram_ce", ram_ce_a[0], 0);
      end else begin
        mon_r = ram_q.pop_front();
        check_eq("ram_issue_cycle", cyc, mon_r.cyc);
        check_eq("ram_addr", ram_addr_a[0], mon_r.addr);
        check_eq("ram_we", ram_we_a[0], mon_r.we);
        if (mon_r.we) check_eq("ram_wdata", ram_wdata_a[0], mon_r.wdata);
      end
    end
    for (int k = 0; k < NI; k++) begin
      if (d_ack_a[k] === 1'b1) handle_ack(k, 1'b0);
      if (i_ack_a[k] === 1'b1) handle_ack(k, 1'b1);
    end
  end

  // ------------------------------------------------------------- requesters
  task automatic drop_req(int k, bit fetch);
    if (fetch) i_req_a[k] = 1'b0;
    else       d_req_a[k] = 1'b0;
  endtask

  // Bounded wait for the requester's ack; optionally checks its stall each
  // cycle and releases req in the ack cycle.
  task automatic wait_ack(int k, bit fetch, int ack_c, bit chk_stall, bit drop);
    bit done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (chk_stall)
        check_eq($sformatf("stall_c%0d", cyc - (ack_c - 2 - lat_of(k))),
                 fetch ? stall_if_a[k] : stall_mem_a[k], (cyc != ack_c));
      if ((fetch ? i_ack_a[k] : d_ack_a[k]) === 1'b1) begin
        done = 1'b1;
        if (drop) drop_req(k, fetch);
      end
    end
    if (!done) begin
      check_eq($sformatf("ack_timeout[%0d]", k), fetch ? i_ack_a[k] : d_ack_a[k], 1);
      drop_req(k, fetch);
    end
  endtask

  task automatic xfer(int k, bit fetch, bit we, logic [AW-1:0] addr,
                      logic [DW-1:0] wdata, bit chk_stall);
    int c0;
    @(posedge clk); #1;
    if (fetch) begin
      i_req_a[k] = 1'b1; i_addr_a[k] = addr;
    end else begin
      d_req_a[k] = 1'b1; d_we_a[k] = we; d_addr_a[k] = addr; d_wdata_a[k] = wdata;
    end
    c0 = cyc;
    expect_xfer(k, fetch, we, addr, wdata, c0);
    wait_ack(k, fetch, ack_cycle(k, fetch, we, c0), chk_stall, 1'b1);
  endtask

  // ------------------------------------------------------------------- main
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    bit fj;
    for (int k = 0; k < NI; k++) begin
      d_req_a[k] = 1'b0; d_we_a[k] = 1'b0; d_addr_a[k] = '0; d_wdata_a[k] = '0;
      i_req_a[k] = 1'b0; i_addr_a[k] = '0;
    end

    // Reset with both requests already asserted.
    rst = 1'b1;
    d_req_a[0] = 1'b1; d_addr_a[0] = 32'h50;
    i_req_a[0] = 1'b1; i_addr_a[0] = 32'h54;
    @(negedge clk);
    check_eq("rst_ram_ce",    ram_ce_a[0],    0);
    check_eq("rst_ram_we",    ram_we_a[0],    0);
    check_eq("rst_d_ack",     d_ack_a[0],     0);
    check_eq("rst_i_ack",     i_ack_a[0],     0);
    check_eq("rst_ram_addr",  ram_addr_a[0],  0);
    check_eq("rst_ram_wdata", ram_wdata_a[0], 0);
    check_eq("rst_d_rdata",   d_rdata_a[0],   0);
    check_eq("rst_i_rdata",   i_rdata_a[0],   0);
    @(posedge clk); #1;
    rst = 1'b0;
    c0 = cyc;
    expect_xfer(0, 1'b0, 1'b0, 32'h50, '0, c0);
    expect_xfer(0, 1'b1, 1'b0, 32'h54, '0, c0 + 5);
    @(negedge clk);
    check_eq("post_rst_idle_ram_ce", ram_ce_a[0], 0);
    wait_ack(0, 1'b0, c0 + 4, 1'b0, 1'b1);
    wait_ack(0, 1'b1, c0 + 9, 1'b0, 1'b1);

    // Single load, single store, single fetch.
    xfer(0, 1'b0, 1'b0, 32'h10, '0, 1'b1);
    xfer(0, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 1'b0);
    xfer(0, 1'b1, 1'b0, 32'h64, '0, 1'b0);
    xfer(0, 1'b0, 1'b1, 32'h24, 32'hCAFE_F00D, 1'b0);

    // Contention: D,D,D,D,I,D,D,D,D,I then a final D once fetch has gone.
    @(posedge clk); #1;
    d_req_a[0] = 1'b1; d_we_a[0] = 1'b0; d_addr_a[0] = 32'h40;
    i_req_a[0] = 1'b1; i_addr_a[0] = 32'h80;
    c0 = cyc;
    for (int j = 0; j < 11; j++) begin
      fj = (j == 4) || (j == 9);
      expect_xfer(0, fj, 1'b0, fj ? 32'h80 : 32'h40, '0, c0 + 5 * j);
    end
    for (int j = 0; j < 11; j++) begin
      fj = (j == 4) || (j == 9);
      wait_ack(0, fj, c0 + 5 * j + 4, 1'b0, j >= 9);
    end

    // Reset pulsed during WAIT of a load; the load must restart cleanly.
    @(posedge clk); #1;
    d_req_a[0] = 1'b1; d_we_a[0] = 1'b0; d_addr_a[0] = 32'h30;
    c0 = cyc;
    mon_r.cyc = c0 + 1; mon_r.we = 1'b0; mon_r.addr = 32'h30; mon_r.wdata = '0;
    ram_q.push_back(mon_r);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_ram_ce_in_rst", ram_ce_a[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    expect_xfer(0, 1'b0, 1'b0, 32'h30, '0, c0 + 3);
    @(negedge clk);
    check_eq("midrst_ram_ce_after", ram_ce_a[0], 0);
    check_eq("midrst_d_ack",        d_ack_a[0],  0);
    check_eq("midrst_d_rdata",      d_rdata_a[0], 0);
    wait_ack(0, 1'b0, c0 + 7, 1'b0, 1'b1);

    // Latency sweep.
    xfer(1, 1'b1, 1'b0, 32'h44, '0, 1'b0);
    xfer(2, 1'b1, 1'b0, 32'h48, '0, 1'b0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("ram_queue_drained", ram_q.size(), 0);
    check_eq("ack_queue_drained", ack_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
